sobel_data_buffer: RTL and testbench
====================================

Name:
sobel_data_buffer

Overview:
- Streaming 3x3 neighbourhood (window) generator for the Sobel edge-detection pipeline.
- Accepts one raster-order pixel per enabled clock.
- Uses two row-delay line buffers (FIFO plus 3-tap shift register per row) to present the 3x3 window ending at the most recent pixel on nine parallel outputs.
- Counts pixels per frame and pulses done_o after the last pixel of a ROWS x COLS frame.

Parameters:
- DEPTH_1, default 3: depth of FIFO feeding the top window row (middle row -> top row). Must equal COLS-3.
- DEPTH_2, default 3: depth of FIFO feeding the middle window row (bottom row -> middle row). Must equal COLS-3.
- ROWS, default 5: frame height in pixels.
- COLS, default 6: frame width in pixels; must be >= 4.
- DATA_WIDTH, default 8: pixel width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- we_i  input  1  pixel valid/write enable; state advances only when high.
- data_i  input  DATA_WIDTH  incoming pixel, raster order.
- d0_o..d2_o  output  DATA_WIDTH each  top window row, left to right (oldest row).
- d3_o..d5_o  output  DATA_WIDTH each  middle window row, left to right.
- d6_o..d8_o  output  DATA_WIDTH each  bottom window row, left to right; d8_o is the newest pixel.
- done_o  output  1  end-of-frame pulse.

Behaviour:
- Reset (async, rst=1): all window registers, FIFO contents/pointers, pixel counter and done_o cleared to 0. Outputs read 0 while rst is high.
- Datapath per rising edge with we_i=1, all stages shift simultaneously:
  - Bottom row: d8 <= data_i, d7 <= d8, d6 <= d7. Old d6 pushed into FIFO2 (DEPTH_2).
  - Middle row: d5 <= FIFO2 output, d4 <= d5, d3 <= d4. Old d3 pushed into FIFO1 (DEPTH_1).
  - Top row: d2 <= FIFO1 output, d1 <= d2, d0 <= d1.
- Resulting row delay = 3 + DEPTH = COLS pixels, so d5 = pixel exactly COLS before d8 and d2 = pixel exactly 2*COLS before d8.
- FIFOs are fixed-length delay lines: one push and one pop per enabled cycle, never full/empty-stalled. Until primed, their outputs are the reset zeros.
- we_i=0: every register, FIFO and counter holds; outputs unchanged. Arbitrary gaps are allowed and change no result.
- Outputs are registers; latency from data_i sampled to d8_o = 1 clock.
- First fully valid window (all nine taps from the current frame) appears after pixel 2*COLS+3 is accepted.
- Window taps straddle row boundaries at row edges. No masking is done; downstream discards invalid positions.
- Pixel counter 0..ROWS*COLS-1 increments on each accepted pixel.
- On the edge accepting pixel ROWS*COLS:
  - Counter wraps to 0.
  - done_o is set to 1 for exactly one clock, then cleared at the next rising edge regardless of we_i.
- Line-buffer contents are not cleared at the frame boundary; the next frame streams in continuously.
- Reset asserted mid-frame: immediate clear, counter restarts at 0, any pending done_o is dropped.

Test Plan:
- Reset: rst=1 for one cycle with we_i=0 -> all d*_o = 0, done_o = 0; hold rst, toggle data_i -> outputs stay 0.
- Fill: default params, write values 1..15 on consecutive cycles.
  - After the 15th edge: d0..d8 = 1,2,3,7,8,9,13,14,15.
  - After the 1st edge: d8=1, all others 0.
- Full frame: write 1..30 continuously.
  - After the 30th edge: d0..d8 = 16,17,18,22,23,24,28,29,30, done_o=1.
  - Next edge (we_i=0): done_o=0, window unchanged.
- Stall: write 1..10, drop we_i for 5 cycles, resume 11..30 -> outputs frozen during the gap; final window and done_o identical to the continuous case.
- Mid-frame reset: write 1..20, assert rst, then write 1..30 -> all outputs 0 during rst; done_o pulses only after the 30th pixel following reset.
- Back-to-back frames: write 60 pixels (1..60) -> done_o pulses after pixels 30 and 60 only; after pixel 60, d0..d8 = 46,47,48,52,53,54,58,59,60.

Source files
------------

// File: rtl/sobel_data_buffer.sv
// Streaming 3x3 window generator for the Sobel pipeline: two row-delay lines
// (fixed-length FIFO + 3-tap shift row) plus a frame pixel counter with done pulse.
module sobel_data_buffer #(
    parameter int DEPTH_1    = 3,
    parameter int DEPTH_2    = 3,
    parameter int ROWS       = 5,
    parameter int COLS       = 6,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] d0_o,
    output logic [DATA_WIDTH-1:0] d1_o,
    output logic [DATA_WIDTH-1:0] d2_o,
    output logic [DATA_WIDTH-1:0] d3_o,
    output logic [DATA_WIDTH-1:0] d4_o,
    output logic [DATA_WIDTH-1:0] d5_o,
    output logic [DATA_WIDTH-1:0] d6_o,
    output logic [DATA_WIDTH-1:0] d7_o,
    output logic [DATA_WIDTH-1:0] d8_o,
    output logic                  done_o
);

    localparam int NPIX  = ROWS * COLS;
    localparam int CNT_W = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NPIX - 1);

    // Index 0 is the leftmost (oldest) tap of each window row.
    logic [DATA_WIDTH-1:0] top_q [3];
    logic [DATA_WIDTH-1:0] top_d [3];
    logic [DATA_WIDTH-1:0] mid_q [3];
    logic [DATA_WIDTH-1:0] mid_d [3];
    logic [DATA_WIDTH-1:0] bot_q [3];
    logic [DATA_WIDTH-1:0] bot_d [3];

    logic [DATA_WIDTH-1:0] fifo1_q [DEPTH_1];
    logic [DATA_WIDTH-1:0] fifo1_d [DEPTH_1];
    logic [DATA_WIDTH-1:0] fifo2_q [DEPTH_2];
    logic [DATA_WIDTH-1:0] fifo2_d [DEPTH_2];

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    always_comb begin
        // NOTE: every _d starts as its _q (done as 0) so no path leaves a latch.
        top_d   = top_q;
        mid_d   = mid_q;
        bot_d   = bot_q;
        fifo1_d = fifo1_q;
        fifo2_d = fifo2_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        if (we_i) begin
            bot_d[2] = data_i;
            bot_d[1] = bot_q[2];
            bot_d[0] = bot_q[1];

            fifo2_d[0] = bot_q[0];
            for (int i = 1; i < DEPTH_2; i++) fifo2_d[i] = fifo2_q[i-1];

            mid_d[2] = fifo2_q[DEPTH_2-1];
            mid_d[1] = mid_q[2];
            mid_d[0] = mid_q[1];

            fifo1_d[0] = mid_q[0];
            for (int i = 1; i < DEPTH_1; i++) fifo1_d[i] = fifo1_q[i-1];

            top_d[2] = fifo1_q[DEPTH_1-1];
            top_d[1] = top_q[2];
            top_d[0] = top_q[1];

            if (cnt_q == LAST_PIX) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: line buffers are reset too, so unprimed taps read as zero.
            for (int i = 0; i < 3; i++) begin
                top_q[i] <= '0;
                mid_q[i] <= '0;
                bot_q[i] <= '0;
            end
            for (int i = 0; i < DEPTH_1; i++) fifo1_q[i] <= '0;
            for (int i = 0; i < DEPTH_2; i++) fifo2_q[i] <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            top_q   <= top_d;
            mid_q   <= mid_d;
            bot_q   <= bot_d;
            fifo1_q <= fifo1_d;
            fifo2_q <= fifo2_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign d0_o   = top_q[0];
    assign d1_o   = top_q[1];
    assign d2_o   = top_q[2];
    assign d3_o   = mid_q[0];
    assign d4_o   = mid_q[1];
    assign d5_o   = mid_q[2];
    assign d6_o   = bot_q[0];
    assign d7_o   = bot_q[1];
    assign d8_o   = bot_q[2];
    assign done_o = done_q;

endmodule

// File: tb/tb_sobel_data_buffer.sv
// Directed bench for sobel_data_buffer with default parameters (5x6 frame).
// Pixel values equal their 1-based index since reset, so taps follow fixed offsets.
module tb_sobel_data_buffer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       we_i = 1'b0;
    logic [7:0] data_i = '0;
    logic [7:0] d0_o, d1_o, d2_o, d3_o, d4_o, d5_o, d6_o, d7_o, d8_o;
    logic       done_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sobel_data_buffer dut (
        .clk    (clk),
        .rst    (rst),
        .we_i   (we_i),
        .data_i (data_i),
        .d0_o   (d0_o),
        .d1_o   (d1_o),
        .d2_o   (d2_o),
        .d3_o   (d3_o),
        .d4_o   (d4_o),
        .d5_o   (d5_o),
        .d6_o   (d6_o),
        .d7_o   (d7_o),
        .d8_o   (d8_o),
        .done_o (done_o)
    );

    logic [7:0] win [9];
    assign win[0] = d0_o;
    assign win[1] = d1_o;
    assign win[2] = d2_o;
    assign win[3] = d3_o;
    assign win[4] = d4_o;
    assign win[5] = d5_o;
    assign win[6] = d6_o;
    assign win[7] = d7_o;
    assign win[8] = d8_o;

    // Tap k holds the pixel this many positions before the newest (row delay = 6).
    function automatic logic [7:0] exp_tap(input int p, input int k);
        int off [9] = '{14, 13, 12, 8, 7, 6, 2, 1, 0};
        int v;
        v = p - off[k];
        return (v > 0) ? 8'(v) : 8'd0;
    endfunction

    task automatic step_write(input int v);
        we_i   = 1'b1;
        data_i = 8'(v);
        @(posedge clk);
        #1;
        we_i = 1'b0;
    endtask

    task automatic step_idle();
        we_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        we_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        we_i = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (win[k] !== 8'd0) begin
                errors++;
                $display("FAIL reset_d%0d: got %0d expected 0", k, win[k]);
            end
        end
        checks++;
        if (done_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_done: got %b expected 0", done_o);
        end
        for (int c = 0; c < 3; c++) begin
            we_i   = 1'b1;
            data_i = 8'(8'hA5 ^ c);
            @(posedge clk);
            #1;
            checks++;
            if (d8_o !== 8'd0 || d5_o !== 8'd0 || done_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: got d8=%0d d5=%0d done=%b expected 0", d8_o, d5_o, done_o);
            end
        end
        we_i = 1'b0;
        rst  = 1'b0;
    endtask

    task automatic test_fill();
        do_reset();
        step_write(1);
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (win[k] !== ((k == 8) ? 8'd1 : 8'd0)) begin
                errors++;
                $display("FAIL fill_first_d%0d: got %0d expected %0d", k, win[k], (k == 8) ? 1 : 0);
            end
        end
        for (int p = 2; p <= 15; p++) step_write(p);
        for (int k = 0; k < 9; k++) begin
            logic [7:0] e [9] = '{8'd1, 8'd2, 8'd3, 8'd7, 8'd8, 8'd9, 8'd13, 8'd14, 8'd15};
            checks++;
            if (win[k] !== e[k]) begin
                errors++;
                $display("FAIL fill_15_d%0d: got %0d expected %0d", k, win[k], e[k]);
            end
        end
        checks++;
        if (done_o !== 1'b0) begin
            errors++;
            $display("FAIL fill_done: got %b expected 0", done_o);
        end
    endtask

    task automatic test_full_frame();
        logic [7:0] e [9] = '{8'd16, 8'd17, 8'd18, 8'd22, 8'd23, 8'd24, 8'd28, 8'd29, 8'd30};
        do_reset();
        for (int p = 1; p <= 30; p++) begin
            step_write(p);
            checks++;
            if (done_o !== (p == 30)) begin
                errors++;
                $display("FAIL frame_done_p%0d: got %b expected %b", p, done_o, p == 30);
            end
        end
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (win[k] !== e[k]) begin
                errors++;
                $display("FAIL frame_30_d%0d: got %0d expected %0d", k, win[k], e[k]);
            end
        end
        step_idle();
        checks++;
        if (done_o !== 1'b0) begin
            errors++;
            $display("FAIL frame_done_clear: got %b expected 0", done_o);
        end
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (win[k] !== e[k]) begin
                errors++;
                $display("FAIL frame_hold_d%0d: got %0d expected %0d", k, win[k], e[k]);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        for (int p = 1; p <= 10; p++) step_write(p);
        for (int g = 0; g < 5; g++) begin
            we_i   = 1'b0;
            data_i = 8'(8'hF0 + g);
            @(posedge clk);
            #1;
            for (int k = 0; k < 9; k++) begin
                checks++;
                if (win[k] !== exp_tap(10, k)) begin
                    errors++;
                    $display("FAIL stall_gap%0d_d%0d: got %0d expected %0d", g, k, win[k], exp_tap(10, k));
                end
            end
        end
        for (int p = 11; p <= 30; p++) begin
            step_write(p);
            checks++;
            if (done_o !== (p == 30)) begin
                errors++;
                $display("FAIL stall_done_p%0d: got %b expected %b", p, done_o, p == 30);
            end
        end
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (win[k] !== exp_tap(30, k)) begin
                errors++;
                $display("FAIL stall_30_d%0d: got %0d expected %0d", k, win[k], exp_tap(30, k));
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int p = 1; p <= 20; p++) step_write(p);
        rst = 1'b1;
        #1;
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (win[k] !== 8'd0) begin
                errors++;
                $display("FAIL midrst_d%0d: got %0d expected 0", k, win[k]);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int p = 1; p <= 30; p++) begin
            step_write(p);
            checks++;
            if (done_o !== (p == 30)) begin
                errors++;
                $display("FAIL midrst_done_p%0d: got %b expected %b", p, done_o, p == 30);
            end
        end
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (win[k] !== exp_tap(30, k)) begin
                errors++;
                $display("FAIL midrst_30_d%0d: got %0d expected %0d", k, win[k], exp_tap(30, k));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e [9] = '{8'd46, 8'd47, 8'd48, 8'd52, 8'd53, 8'd54, 8'd58, 8'd59, 8'd60};
        do_reset();
        for (int p = 1; p <= 60; p++) begin
            step_write(p);
            checks++;
            if (done_o !== (p == 30 || p == 60)) begin
                errors++;
                $display("FAIL b2b_done_p%0d: got %b expected %b", p, done_o, p == 30 || p == 60);
            end
            if (p == 37) begin
                for (int k = 0; k < 9; k++) begin
                    checks++;
                    if (win[k] !== exp_tap(37, k)) begin
                        errors++;
                        $display("FAIL b2b_37_d%0d: got %0d expected %0d", k, win[k], exp_tap(37, k));
                    end
                end
            end
        end
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (win[k] !== e[k]) begin
                errors++;
                $display("FAIL b2b_60_d%0d: got %0d expected %0d", k, win[k], e[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_frame();
        test_stall();
        test_mid_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
